// File: rtl/clock_pkg.sv
// Shared definitions for the clock time-setting logic: field widths,
// field limits, the setter FSM state set and the field encodings.
package clock_pkg;

    localparam int TIME_W = 17;
    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    // Limits are carried at minute/second width so one wrap helper serves all fields.
    localparam logic [MIN_W-1:0] MAX_HOUR = 6'd23;
    localparam logic [MIN_W-1:0] MAX_MIN  = 6'd59;
    localparam logic [MIN_W-1:0] MAX_SEC  = 6'd59;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET_HOUR,
        ST_SET_MIN,
        ST_SET_SEC,
        ST_COMMIT
    } state_t;

    typedef enum logic [1:0] {
        FIELD_NONE = 2'd0,
        FIELD_HOUR = 2'd1,
        FIELD_MIN  = 2'd2,
        FIELD_SEC  = 2'd3
    } field_t;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  minute;
        logic [SEC_W-1:0]  second;
    } clock_time_t;

    // Increment with wrap; anything at or above the limit (including
    // out-of-range captured values) lands on zero.
    function automatic logic [MIN_W-1:0] wrap_inc(input logic [MIN_W-1:0] v,
                                                  input logic [MIN_W-1:0] lim);
        return (v >= lim) ? '0 : v + 6'd1;
    endfunction

    // Decrement with wrap; zero and out-of-range values land on the limit.
    function automatic logic [MIN_W-1:0] wrap_dec(input logic [MIN_W-1:0] v,
                                                  input logic [MIN_W-1:0] lim);
        return (v == '0 || v > lim) ? lim : v - 6'd1;
    endfunction

endpackage

// File: rtl/btn_edge_repeat.sv
// Rising-edge detector with press-and-hold auto-repeat. Emits a one-cycle
// step on the press edge, again after REPEAT_DLY held cycles, then every
// REPEAT_PER held cycles. Releasing the button or dropping enable disarms it.
module btn_edge_repeat #(
    parameter logic [31:0] REPEAT_DLY = 32'd50_000_000,
    parameter logic [31:0] REPEAT_PER = 32'd10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    input  logic enable,
    output logic step
);

    logic        btn_prev;
    logic        repeating;
    logic [31:0] hold_cnt;
    logic        edge_det;
    logic        armed;
    logic        hit;

    // hold_cnt == k means the current cycle is the k-th held cycle after the
    // press edge; zero means not armed (no edge seen while enabled).
    assign edge_det = btn & ~btn_prev;
    assign armed    = (hold_cnt != 32'd0);
    assign hit      = armed & btn &
                      (repeating ? (hold_cnt == REPEAT_PER) : (hold_cnt == REPEAT_DLY));
    assign step     = enable & btn & (edge_det | hit);

    // Previous-sample register; resets high so a button held through reset
    // release is not seen as a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            btn_prev <= btn;
        end
    end

    // Hold counter: restart on edge, reload after each repeat hit, clear on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt  <= 32'd0;
            repeating <= 1'b0;
        end else if (!enable || !btn) begin
            hold_cnt  <= 32'd0;
            repeating <= 1'b0;
        end else if (edge_det) begin
            hold_cnt  <= 32'd1;
            repeating <= 1'b0;
        end else if (hit) begin
            hold_cnt  <= 32'd1;
            repeating <= 1'b1;
        end else if (armed) begin
            hold_cnt  <= hold_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/time_setter.sv
// Front-panel time-setting FSM. Captures the live time into a shadow
// register, lets the user walk hour/min/sec with inc/dec (with auto-repeat),
// and issues a one-cycle overwrite strobe with the edited time on commit.
module time_setter
    import clock_pkg::*;
#(
    parameter logic [31:0] REPEAT_DLY = 32'd50_000_000,
    parameter logic [31:0] REPEAT_PER = 32'd10_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TIME_W-1:0] time_cur,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic              btn_dec,
    input  logic              btn_cancel,
    output logic [TIME_W-1:0] time_set,
    output logic              time_ow,
    output logic              editing,
    output logic [1:0]        field
);

    state_t      state_q, state_d;
    clock_time_t shadow_q, shadow_d;
    field_t      field_d;
    logic        editing_d;
    logic        time_ow_d;

    logic        mode_prev, cancel_prev;
    logic        mode_edge, cancel_edge;
    logic        in_set;
    logic        inc_step, dec_step;
    logic [MIN_W-1:0] stepped;

    assign mode_edge   = btn_mode   & ~mode_prev;
    assign cancel_edge = btn_cancel & ~cancel_prev;
    assign in_set      = (state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN) ||
                         (state_q == ST_SET_SEC);
    assign time_set    = shadow_q;

    btn_edge_repeat #(
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) u_inc (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn    (btn_inc),
        .enable (in_set),
        .step   (inc_step)
    );

    btn_edge_repeat #(
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) u_dec (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn    (btn_dec),
        .enable (in_set),
        .step   (dec_step)
    );

    // Plain edge registers for mode and cancel; reset high to suppress held buttons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_prev   <= 1'b1;
            cancel_prev <= 1'b1;
        end else begin
            mode_prev   <= btn_mode;
            cancel_prev <= btn_cancel;
        end
    end

    // Next-state and shadow update; cancel beats mode, both beat a field step.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        shadow_d = shadow_q;
        stepped  = '0;

        case (state_q)
            ST_IDLE: begin
                if (mode_edge) begin
                    shadow_d = clock_time_t'(time_cur);
                    state_d  = ST_SET_HOUR;
                end
            end

            ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC: begin
                if (cancel_edge) begin
                    state_d = ST_IDLE;
                end else if (mode_edge) begin
                    case (state_q)
                        ST_SET_HOUR: state_d = ST_SET_MIN;
                        ST_SET_MIN:  state_d = ST_SET_SEC;
                        default:     state_d = ST_COMMIT;
                    endcase
                end else if (inc_step ^ dec_step) begin
                    case (state_q)
                        ST_SET_HOUR: begin
                            stepped = inc_step ? wrap_inc({1'b0, shadow_q.hour}, MAX_HOUR)
                                               : wrap_dec({1'b0, shadow_q.hour}, MAX_HOUR);
                            shadow_d.hour = stepped[HOUR_W-1:0];
                        end
                        ST_SET_MIN: begin
                            stepped = inc_step ? wrap_inc(shadow_q.minute, MAX_MIN)
                                               : wrap_dec(shadow_q.minute, MAX_MIN);
                            shadow_d.minute = stepped;
                        end
                        default: begin
                            stepped = inc_step ? wrap_inc(shadow_q.second, MAX_SEC)
                                               : wrap_dec(shadow_q.second, MAX_SEC);
                            shadow_d.second = stepped;
                        end
                    endcase
                end
            end

            ST_COMMIT: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    // Output decodes computed from next state so the registered copies line up with state_q.
    always_comb begin
        editing_d = 1'b0;
        time_ow_d = 1'b0;
        field_d   = FIELD_NONE;
        case (state_d)
            ST_SET_HOUR: begin editing_d = 1'b1; field_d = FIELD_HOUR; end
            ST_SET_MIN:  begin editing_d = 1'b1; field_d = FIELD_MIN;  end
            ST_SET_SEC:  begin editing_d = 1'b1; field_d = FIELD_SEC;  end
            ST_COMMIT:   time_ow_d = 1'b1;
            default:     ;
        endcase
    end

    // State, shadow and registered output decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            editing  <= 1'b0;
            time_ow  <= 1'b0;
            field    <= FIELD_NONE;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            editing  <= editing_d;
            time_ow  <= time_ow_d;
            field    <= field_d;
        end
    end

endmodule

// File: tb/tb_time_setter.sv
// Self-checking bench for time_setter: directed scenarios followed by random
// button activity, all checked cycle by cycle against a behavioural model
// through a scoreboard queue drained by an independent monitor.
module tb_time_setter;

    localparam int DLY = 8;
    localparam int PER = 4;

    logic        clk;
    logic        rst_n;
    logic [16:0] time_cur;
    logic        btn_mode, btn_inc, btn_dec, btn_cancel;
    logic [16:0] time_set;
    logic        time_ow;
    logic        editing;
    logic [1:0]  field;

    time_setter #(
        .REPEAT_DLY (32'd8),
        .REPEAT_PER (32'd4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .time_cur   (time_cur),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .btn_dec    (btn_dec),
        .btn_cancel (btn_cancel),
        .time_set   (time_set),
        .time_ow    (time_ow),
        .editing    (editing),
        .field      (field)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int ow_seen  = 0;

    typedef struct packed {
        logic [16:0] ts;
        logic        ow;
        logic        ed;
        logic [1:0]  fld;
    } snap_t;

    snap_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0=idle, 1=hour, 2=min, 3=sec, 4=commit.
    int       m_state;
    int       m_h, m_m, m_s;
    bit       p_mode, p_inc, p_dec, p_cancel;
    int       inc_len, dec_len;

    task automatic model_reset();
        m_state = 0;
        m_h = 0; m_m = 0; m_s = 0;
        p_mode = 1; p_inc = 1; p_dec = 1; p_cancel = 1;
        inc_len = -1; dec_len = -1;
    endtask

    // len = held cycles since the press edge, -1 when not armed.
    task automatic rep(input bit lvl, input bit edg, input bit en, inout int len, output bit st);
        st = 0;
        if (!en || !lvl) len = -1;
        else if (edg) begin len = 0; st = 1; end
        else if (len >= 0) begin
            len++;
            if (len == DLY || (len > DLY && (len - DLY) % PER == 0)) st = 1;
        end
    endtask

    function automatic int step_val(input int v, input int lim, input bit up);
        if (up) return (v >= lim) ? 0 : v + 1;
        return (v == 0 || v > lim) ? lim : v - 1;
    endfunction

    task automatic model_update();
        bit me, ce, ie, de, en, is, ds;
        snap_t e;
        me = btn_mode & ~p_mode;
        ce = btn_cancel & ~p_cancel;
        ie = btn_inc & ~p_inc;
        de = btn_dec & ~p_dec;
        en = (m_state >= 1 && m_state <= 3);
        rep(btn_inc, ie, en, inc_len, is);
        rep(btn_dec, de, en, dec_len, ds);
        if (m_state == 0) begin
            if (me) begin
                m_h = int'(time_cur[16:12]);
                m_m = int'(time_cur[11:6]);
                m_s = int'(time_cur[5:0]);
                m_state = 1;
            end
        end else if (m_state == 4) begin
            m_state = 0;
        end else if (ce) begin
            m_state = 0;
        end else if (me) begin
            m_state = m_state + 1;
        end else if (is != ds) begin
            case (m_state)
                1: m_h = step_val(m_h, 23, is);
                2: m_m = step_val(m_m, 59, is);
                default: m_s = step_val(m_s, 59, is);
            endcase
        end
        p_mode = btn_mode; p_cancel = btn_cancel; p_inc = btn_inc; p_dec = btn_dec;
        e.ts  = {5'(m_h), 6'(m_m), 6'(m_s)};
        e.ow  = (m_state == 4);
        e.ed  = (m_state >= 1 && m_state <= 3);
        e.fld = e.ed ? 2'(m_state) : 2'd0;
        exp_q.push_back(e);
    endtask

    // Monitor: one expected snapshot per stimulus cycle, compared mid-cycle.
    initial begin
        snap_t e;
        forever begin
            @(negedge clk);
            if (time_ow === 1'b1) ow_seen++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("time_set", 32'(time_set), 32'(e.ts));
                check("time_ow",  32'(time_ow),  32'(e.ow));
                check("editing",  32'(editing),  32'(e.ed));
                check("field",    32'(field),    32'(e.fld));
            end
        end
    end

    task automatic tick(input bit m, input bit i, input bit d, input bit c);
        btn_mode = m; btn_inc = i; btn_dec = d; btn_cancel = c;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic pulse_mode();
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst time_set", 32'(time_set), 32'd0);
        check("rst time_ow",  32'(time_ow),  32'd0);
        check("rst editing",  32'(editing),  32'd0);
        check("rst field",    32'(field),    32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int ow_base;

    initial begin
        rst_n = 1'b1;
        time_cur = '0;
        btn_mode = 0; btn_inc = 0; btn_dec = 0; btn_cancel = 0;
        model_reset();
        do_reset();

        // Hour wrap 23 -> 0 and a full commit.
        time_cur = {5'd23, 6'd48, 6'd0};
        tick(0, 0, 0, 0);
        pulse_mode();
        time_cur = {5'd5, 6'd1, 6'd2};
        tick(0, 1, 0, 0);
        tick(0, 0, 0, 0);
        check("hour wrap", 32'(time_set), 32'({5'd0, 6'd48, 6'd0}));
        ow_base = ow_seen;
        pulse_mode();
        pulse_mode();
        tick(1, 0, 0, 0);
        check("commit strobe", 32'(time_ow), 32'd1);
        check("commit value", 32'(time_set), 32'({5'd0, 6'd48, 6'd0}));
        tick(0, 0, 0, 0);
        check("back to idle", 32'(editing), 32'd0);
        repeat (3) tick(0, 0, 0, 0);
        check("one strobe", 32'(ow_seen - ow_base), 32'd1);

        // Minute wrap 0 -> 59 on dec.
        time_cur = {5'd7, 6'd0, 6'd33};
        pulse_mode();
        pulse_mode();
        tick(0, 0, 1, 0);
        tick(0, 0, 0, 0);
        check("min dec wrap", 32'(time_set), 32'({5'd7, 6'd59, 6'd33}));
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);

        // Held inc with auto-repeat, then release and hold again.
        time_cur = {5'd2, 6'd3, 6'd10};
        pulse_mode();
        pulse_mode();
        pulse_mode();
        check("in sec field", 32'(field), 32'd3);
        repeat (21) tick(0, 1, 0, 0);
        check("repeat sec", 32'(time_set[5:0]), 32'd15);
        repeat (2) tick(0, 0, 0, 0);
        repeat (9) tick(0, 1, 0, 0);
        check("repeat restart", 32'(time_set[5:0]), 32'd17);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);

        // Mode beats inc; simultaneous inc/dec does nothing.
        time_cur = {5'd4, 6'd20, 6'd5};
        pulse_mode();
        pulse_mode();
        tick(1, 1, 0, 0);
        check("mode wins field", 32'(field), 32'd3);
        check("mode wins value", 32'(time_set), 32'({5'd4, 6'd20, 6'd5}));
        tick(0, 0, 0, 0);
        tick(0, 1, 1, 0);
        check("inc+dec none", 32'(time_set), 32'({5'd4, 6'd20, 6'd5}));
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);

        // Cancel from SET_MIN: no strobe.
        pulse_mode();
        pulse_mode();
        ow_base = ow_seen;
        tick(0, 0, 0, 1);
        check("cancel editing", 32'(editing), 32'd0);
        repeat (20) tick(0, 0, 0, 0);
        check("cancel no ow", 32'(ow_seen - ow_base), 32'd0);

        // Reset mid-edit with mode held through release.
        tick(1, 0, 0, 0);
        check("pre-reset field", 32'(field), 32'd1);
        do_reset();
        repeat (5) tick(1, 0, 0, 0);
        check("held mode no edge", 32'(field), 32'd0);
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        check("toggle mode edge", 32'(field), 32'd1);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);

        // Random activity, including out-of-range captured times.
        begin
            bit m, i, d, c;
            m = 0; i = 0; d = 0; c = 0;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 39) == 0) time_cur = 17'($urandom);
                if ($urandom_range(0, 7) == 0)  m = ~m;
                if ($urandom_range(0, 5) == 0)  i = ~i;
                if ($urandom_range(0, 5) == 0)  d = ~d;
                if ($urandom_range(0, 39) == 0) c = ~c;
                if ($urandom_range(0, 699) == 0) begin
                    btn_mode = m; btn_inc = i; btn_dec = d; btn_cancel = c;
                    do_reset();
                end
                tick(m, i, d, c);
            end
        end

        tick(0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
